// File: rtl/window_line_buffer.sv
// Raster-scan 3x3 window generator backed by two line buffers.
// Optional output frame_count is enabled by WINDOW_LINE_BUFFER_FRAME_COUNT_EN.
module window_line_buffer #(
   parameter int PIXEL_BITS = 8,
   parameter int IMG_WIDTH  = 16,
   parameter int IMG_HEIGHT = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic [PIXEL_BITS-1:0]         pixel_in,
   input  logic                          pixel_valid,
   output logic                          pixel_ready,
   output logic [9*PIXEL_BITS-1:0]       window_out,
   output logic                          window_valid,
   input  logic                          window_ready,
   output logic [$clog2(IMG_WIDTH)-1:0]  col_out,
   output logic [$clog2(IMG_HEIGHT)-1:0] row_out,
`ifdef WINDOW_LINE_BUFFER_FRAME_COUNT_EN
   output logic [15:0]                   frame_count,
`endif
   output logic                          frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   typedef logic [PIXEL_BITS-1:0] pix_t;

   pix_t line0 [IMG_WIDTH];
   pix_t line1 [IMG_WIDTH];

   // Only the two newest window columns need storage; the third is incoming.
   pix_t sr      [3][2];
   pix_t sr_next [3][3];
   pix_t col_new [3];

   logic [CW-1:0]           col;
   logic [RW-1:0]           row;
   logic [9*PIXEL_BITS-1:0] win_next;
   logic                    accept;
   logic                    qualify;
   logic                    last_col;
   logic                    last_row;

   assign pixel_ready = !window_valid || window_ready;
   assign accept      = pixel_valid && pixel_ready && !clear;
   assign qualify     = (row >= RW'(2)) && (col >= CW'(2));
   assign last_col    = (col == CW'(IMG_WIDTH - 1));
   assign last_row    = (row == RW'(IMG_HEIGHT - 1));
   assign col_out     = col;
   assign row_out     = row;

   always_comb begin
      col_new[0] = line1[col];
      col_new[1] = line0[col];
      col_new[2] = pixel_in;
      for (int r = 0; r < 3; r++) begin
         sr_next[r][0] = sr[r][0];
         sr_next[r][1] = sr[r][1];
         sr_next[r][2] = col_new[r];
      end
      win_next = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            win_next[PIXEL_BITS*(3*r+c) +: PIXEL_BITS] = sr_next[r][c];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < IMG_WIDTH; i++) begin
            line0[i] <= '0;
            line1[i] <= '0;
         end
      end else if (accept) begin
         line1[col] <= line0[col];
         line0[col] <= pixel_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            sr[r][0] <= '0;
            sr[r][1] <= '0;
         end
      end else if (accept) begin
         for (int r = 0; r < 3; r++) begin
            sr[r][0] <= sr_next[r][1];
            sr[r][1] <= sr_next[r][2];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         window_out   <= '0;
         window_valid <= 1'b0;
      end else if (clear) begin
         window_valid <= 1'b0;
      end else if (accept && qualify) begin
         window_out   <= win_next;
         window_valid <= 1'b1;
      end else if (window_ready) begin
         window_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         frame_done <= 1'b0;
      end else if (clear) begin
         col        <= '0;
         row        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= accept && last_col && last_row;
         if (accept) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
      end
   end

`ifdef WINDOW_LINE_BUFFER_FRAME_COUNT_EN
   // Survives clear so software can count frames across restarts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_count <= '0;
      end else if (accept && last_col && last_row) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer on a 4x4 image.
// Checks frame_count when WINDOW_LINE_BUFFER_FRAME_COUNT_EN is defined.
module tb_window_line_buffer;

   localparam int W = 4;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic [7:0]  pixel_in;
   logic        pixel_valid;
   logic        pixel_ready;
   logic [71:0] window_out;
   logic        window_valid;
   logic        window_ready;
   logic [1:0]  col_out;
   logic [1:0]  row_out;
   logic        frame_done;
`ifdef WINDOW_LINE_BUFFER_FRAME_COUNT_EN
   logic [15:0] frame_count;
`endif

   window_line_buffer #(
      .PIXEL_BITS(8),
      .IMG_WIDTH(W),
      .IMG_HEIGHT(H)
   ) dut (
      .clk(clk),
      .rst(rst),
      .clear(clear),
      .pixel_in(pixel_in),
      .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready),
      .window_out(window_out),
      .window_valid(window_valid),
      .window_ready(window_ready),
      .col_out(col_out),
      .row_out(row_out),
`ifdef WINDOW_LINE_BUFFER_FRAME_COUNT_EN
      .frame_count(frame_count),
`endif
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Model: the frame is an image array; a window is a 3x3 crop of it.
   logic [7:0]  img [H][W];
   logic [1:0]  m_col;
   logic [1:0]  m_row;
   logic        m_valid;
   logic        m_done;
   logic [71:0] m_win;
   logic [15:0] m_cnt;
   wire         m_ready = !m_valid || window_ready;
   wire         m_acc   = pixel_valid && m_ready && !clear;

   function automatic logic [71:0] mk_win(int row, int col, logic [7:0] p);
      logic [71:0] w;
      w = '0;
      for (int rr = 0; rr < 3; rr++)
         for (int cc = 0; cc < 3; cc++)
            w[8*(3*rr+cc) +: 8] = (rr == 2 && cc == 2) ? p
                                  : img[row-2+rr][col-2+cc];
      return w;
   endfunction

   function automatic logic [3:0] adv(int row, int col);
      int p;
      p = (row * W + col + 1) % (W * H);
      return {2'(p / W), 2'(p % W)};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_col   <= '0;
         m_row   <= '0;
         m_valid <= 1'b0;
         m_done  <= 1'b0;
         m_win   <= '0;
         m_cnt   <= '0;
      end else if (clear) begin
         m_col   <= '0;
         m_row   <= '0;
         m_valid <= 1'b0;
         m_done  <= 1'b0;
      end else if (m_acc) begin
         img[m_row][m_col] <= pixel_in;
         {m_row, m_col}    <= adv(int'(m_row), int'(m_col));
         m_done <= (int'(m_row) * W + int'(m_col) == W * H - 1);
         if (int'(m_row) * W + int'(m_col) == W * H - 1)
            m_cnt <= m_cnt + 16'd1;
         if (m_row >= 2'd2 && m_col >= 2'd2) begin
            m_valid <= 1'b1;
            m_win   <= mk_win(int'(m_row), int'(m_col), pixel_in);
         end else begin
            m_valid <= 1'b0;
         end
      end else begin
         m_done <= 1'b0;
         if (window_ready) m_valid <= 1'b0;
      end
   end

   int          tests;
   int          fails;
   int          done_seen;
   bit          armed;
   logic [71:0] q_win [$];

   localparam logic [71:0] FIRST0 = 72'h222120121110020100;
   localparam logic [71:0] FIRST8 = 72'hA2A1A0929190828180;

   task automatic check(string name, logic [71:0] act, logic [71:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (armed && !rst) begin
            check("pixel_ready", 72'(pixel_ready), 72'(m_ready));
            check("window_valid", 72'(window_valid), 72'(m_valid));
            check("window_out", window_out, m_win);
            check("col_out", 72'(col_out), 72'(m_col));
            check("row_out", 72'(row_out), 72'(m_row));
            check("frame_done", 72'(frame_done), 72'(m_done));
`ifdef WINDOW_LINE_BUFFER_FRAME_COUNT_EN
            check("frame_count", 72'(frame_count), 72'(m_cnt));
`endif
            if (window_valid && window_ready) q_win.push_back(window_out);
            if (frame_done) done_seen++;
         end
      end
   endtask

   task automatic send(logic [7:0] v);
      bit ok;
      ok          = 1'b0;
      pixel_in    = v;
      pixel_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = pixel_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) check("send_timeout", 72'(ok), 72'(1));
      pixel_valid = 1'b0;
   endtask

   task automatic frame(logic [7:0] base, bit stall, logic [71:0] first);
      int d0;
      q_win.delete();
      d0 = done_seen;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (stall && r == 2 && c == 3) begin
               window_ready = 1'b0;
               pixel_in     = base + 8'h23;
               pixel_valid  = 1'b1;
               repeat (3) begin
                  @(negedge clk);
                  check("bp_pixel_ready", 72'(pixel_ready), 72'(0));
                  check("bp_window_hold", window_out, first);
                  @(posedge clk);
                  #1;
               end
               window_ready = 1'b1;
            end
            send(base + 8'(16 * r + c));
         end
      end
      check("done_after_last", 72'(frame_done), 72'(1));
      repeat (3) @(posedge clk);
      #1;
      check("window_count", 72'(q_win.size()), 72'(4));
      check("done_pulses", 72'(done_seen - d0), 72'(1));
      if (q_win.size() == 4) begin
         check("first_window", q_win[0], first);
         check("centre_11", 72'(q_win[0][39:32]), 72'(base + 8'h11));
         check("centre_12", 72'(q_win[1][39:32]), 72'(base + 8'h12));
         check("centre_21", 72'(q_win[2][39:32]), 72'(base + 8'h21));
         check("centre_22", 72'(q_win[3][39:32]), 72'(base + 8'h22));
      end
   endtask

   task automatic check_zero(string tag);
      check({tag, "_ready"}, 72'(pixel_ready), 72'(1));
      check({tag, "_valid"}, 72'(window_valid), 72'(0));
      check({tag, "_window"}, window_out, 72'(0));
      check({tag, "_col"}, 72'(col_out), 72'(0));
      check({tag, "_row"}, 72'(row_out), 72'(0));
      check({tag, "_done"}, 72'(frame_done), 72'(0));
   endtask

   task automatic check_count(logic [15:0] exp);
`ifdef WINDOW_LINE_BUFFER_FRAME_COUNT_EN
      check("frame_count_lit", 72'(frame_count), 72'(exp));
`else
      if (exp == 16'hFFFF) $display("unused count %0d", exp);
`endif
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      done_seen    = 0;
      armed        = 1'b0;
      rst          = 1'b0;
      clear        = 1'b0;
      pixel_valid  = 1'b1;
      pixel_in     = 8'h5A;
      window_ready = 1'b1;
      fork
         compare_loop();
      join_none
      #7 rst = 1'b1;
      #1 check_zero("reset");
      pixel_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      armed = 1'b1;

      frame(8'h00, 1'b0, FIRST0);
      check_count(16'd1);
      frame(8'h00, 1'b1, FIRST0);
      check_count(16'd2);

      for (int i = 0; i < 9; i++) send(8'h40 + 8'(16 * (i / W) + i % W));
      pixel_in    = 8'h61;
      pixel_valid = 1'b1;
      clear       = 1'b1;
      @(posedge clk);
      #1;
      clear       = 1'b0;
      pixel_valid = 1'b0;
      check("clear_col", 72'(col_out), 72'(0));
      check("clear_row", 72'(row_out), 72'(0));
      check("clear_valid", 72'(window_valid), 72'(0));
      frame(8'h80, 1'b0, FIRST8);
      check_count(16'd3);

      for (int i = 0; i < 13; i++) send(8'(16 * (i / W) + i % W));
      #3 rst = 1'b1;
      #1 check_zero("midrst");
      check_count(16'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      frame(8'h00, 1'b0, FIRST0);
      check_count(16'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/window_line_buffer.md
# window_line_buffer

Raster-scan 3x3 window generator for the edge-detection datapath. It accepts one pixel per handshake in row-major order and keeps the two previous image rows in line buffers. It emits a complete 3x3 neighbourhood to the downstream gradient stage. Internal column and row counters wrap the same way as the team's flexible counter; no padding windows are generated.

## Interface
- PIXEL_BITS, 8, bits per pixel
- IMG_WIDTH, 16, pixels per row; must be 3 or more
- IMG_HEIGHT, 16, rows per frame; must be 3 or more
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; asynchronous, active-high
- clear  input  1  synchronous frame restart
- pixel_in  input  PIXEL_BITS  incoming pixel
- pixel_valid  input  1  pixel_in is valid
- pixel_ready  output  1  block can accept a pixel this cycle
- window_out  output  9*PIXEL_BITS  3x3 window; entry (r,c) sits at bits [PIXEL_BITS*(3r+c) +: PIXEL_BITS]; r=0 is the top row, c=0 is the left (oldest) column
- window_valid  output  1  window_out is valid
- window_ready  input  1  downstream consumes the window
- col_out  output  $clog2(IMG_WIDTH)  column of the next pixel to be accepted
- row_out  output  $clog2(IMG_HEIGHT)  row of the next pixel to be accepted
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Accept happens when pixel_valid && pixel_ready. pixel_ready = !window_valid || window_ready.
- On each accept, for column col:
  - line1[col] <= line0[col]
  - line0[col] <= pixel_in
  - The 3x3 column shift register shifts left and loads a new right column {line1[col], line0[col], pixel_in} (top, mid, bottom).
- Counters on each accept:
  - col increments.
  - At IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and frame_done pulses.
- Window emission:
  - An accept with row>=2 and col>=2 loads window_out and sets window_valid.
  - The window is centred on pixel (row-1, col-1).
- Other accepts:
  - If window_ready is high, window_valid clears.
  - Otherwise the accept cannot occur, because pixel_ready is low.
- Handshake: window_valid && window_ready with no new qualifying accept clears window_valid.
- Stale columns from the previous row are flushed by the col>=2 gate.
- Stale line-buffer contents are masked by the row>=2 gate.
- Clear:
  - Sets col, row, window_valid and frame_done to 0; window_out and line buffers are left untouched.
  - Has priority over a same-cycle accept; that pixel is dropped.
- Reset: all registers go to 0, including line buffers and window_out.

## Timing
- Reset values:
  - pixel_ready=1
  - window_valid=0, window_out=0
  - col_out=0, row_out=0
  - frame_done=0
- Latency: window_valid rises one cycle after the accepting edge of a qualifying pixel.
- Stall: while window_valid && !window_ready, window_out is held stable and pixel_ready=0.
- Simultaneous consume and qualifying accept: the new window replaces the old one; window_valid stays 1 with no bubble.
- frame_done is high for exactly one cycle, on the cycle after the last-pixel accept.
- Reset mid-frame: the next accepted pixel is (0,0); no window is emitted until (2,2) of the new frame.
- Throughput: one pixel per cycle when window_ready is held high.

## Configuration
- WINDOW_LINE_BUFFER_FRAME_COUNT_EN
  - Defined: adds output frame_count[15:0].
  - It increments in the same cycle frame_done pulses and wraps 16'hFFFF to 0.
  - It is reset to 0 by rst only; clear does not affect it.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset:
  - Stimulus: assert rst mid-cycle with pixel_valid=1.
  - Required: pixel_ready=1, window_valid=0, window_out=0, col_out=row_out=0, frame_done=0.
- Full frame (IMG_WIDTH=IMG_HEIGHT=4):
  - Stimulus: stream pixel=16*row+col back-to-back with window_ready=1.
  - Required: exactly 4 windows, centred (1,1),(1,2),(2,1),(2,2).
  - Required: first window rows {00,01,02},{10,11,12},{20,21,22}.
  - Required: frame_done pulses once, the cycle after 0x33 is accepted.
- Backpressure:
  - Stimulus: hold window_ready=0 for 3 cycles after the first window.
  - Required: pixel_ready=0 and window_out stable for those cycles.
  - Required: after release, the next window is centred (1,2) with no pixel lost.
- Clear mid-frame:
  - Stimulus: pulse clear at row 2, col 1 with pixel_valid=1.
  - Required: that pixel is dropped, col_out=row_out=0, and the next window appears only after the new frame's pixel (2,2).
- Async reset mid-frame:
  - Stimulus: assert rst after pixel (3,0).
  - Required: outputs zero immediately; a following full frame reproduces the full-frame result exactly.
- Macro defined:
  - Stimulus: two full frames, one clear, then a third full frame.
  - Required: frame_count reads 1, 2, then 3; clear does not reset it.
